// File: rtl/matmul_result_streamer_pkg.sv
// Shared matmul constants, streamer state type and index-to-(row,col) mapping.
// MATMUL_STREAM_COLMAJOR_EN selects column-major order; default is row-major.
package matmul_result_streamer_pkg;

   localparam int unsigned MAT_DIM    = 4;
   localparam int unsigned MAT_ELEMS  = MAT_DIM * MAT_DIM;
   localparam int unsigned DATA_W_DEF = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   typedef struct packed {
      logic [1:0] row;
      logic [1:0] col;
   } rc_t;

   function automatic rc_t idx_to_rc(input logic [3:0] k);
      rc_t rc;
`ifdef MATMUL_STREAM_COLMAJOR_EN
      rc.row = k[1:0];
      rc.col = k[3:2];
`else
      rc.row = k[3:2];
      rc.col = k[1:0];
`endif
      return rc;
   endfunction

endpackage

// File: rtl/matmul_result_streamer_if.sv
// Valid/ready element stream carrying one result element per transfer.
interface matmul_result_streamer_if
   import matmul_result_streamer_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic [DATA_W-1:0] m_data;
   logic              m_valid;
   logic              m_ready;
   logic              m_last;

   modport master (output m_data, output m_valid, output m_last, input m_ready);
   modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/matmul_result_streamer.sv
// Buffers a 4x4 result matrix on done and streams its 16 elements over a
// valid/ready interface. Order: row-major, or column-major with MATMUL_STREAM_COLMAJOR_EN.
module matmul_result_streamer
   import matmul_result_streamer_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0] c,
   input  logic                                        done,
   matmul_result_streamer_if.master                    m,
   output logic                                        busy,
   output logic                                        overrun
);

   state_e r_state;
   state_e w_state_nxt;
   logic [3:0] r_idx;
   logic [3:0] w_idx_nxt;
   logic r_overrun;
   logic w_overrun_nxt;
   logic w_load;
   logic w_xfer;
   logic w_at_last;
   rc_t  w_rc;
   logic [0:MAT_DIM-1][0:MAT_DIM-1][DATA_W-1:0] r_buf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_overrun <= w_overrun_nxt;
      end
   end

   // Buffer is qualified by state, so it carries no reset.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_buf <= c;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_idx_nxt     = r_idx;
      w_overrun_nxt = r_overrun;
      w_load        = 1'b0;
      w_at_last     = (r_idx == 4'(MAT_ELEMS - 1));
      w_xfer        = (r_state == STREAM) && m.m_ready;

      unique case (r_state)
         IDLE: begin
            if (done) begin
               w_load      = 1'b1;
               w_idx_nxt   = '0;
               w_state_nxt = STREAM;
            end
         end
         STREAM: begin
            if (w_xfer) begin
               if (w_at_last) begin
                  w_idx_nxt = '0;
                  if (done) begin
                     w_load = 1'b1;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_idx_nxt = r_idx + 4'd1;
               end
            end
            // Only a done coinciding with the final transfer can be absorbed.
            if (done && !(w_xfer && w_at_last)) begin
               w_overrun_nxt = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      w_rc      = idx_to_rc(r_idx);
      busy      = (r_state == STREAM);
      overrun   = r_overrun;
      m.m_valid = busy;
      m.m_last  = busy && (r_idx == 4'(MAT_ELEMS - 1));
      m.m_data  = busy ? r_buf[w_rc.row][w_rc.col] : '0;
   end

endmodule

// File: tb/tb_matmul_result_streamer.sv
// Scoreboard bench: stimulus pushes expected elements, a negedge monitor checks them.
module tb_matmul_result_streamer;
   import matmul_result_streamer_pkg::*;

   localparam int unsigned DW = 16;
   typedef logic [0:3][0:3][DW-1:0] mat_t;
   typedef struct {
      logic [DW-1:0] data;
      logic          last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   mat_t c = '0;
   logic done = 1'b0;
   logic busy;
   logic overrun;

   matmul_result_streamer_if #(.DATA_W(DW)) u_if ();

   matmul_result_streamer #(.DATA_W(DW)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .c       (c),
      .done    (done),
      .m       (u_if),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   rem           = 0;
   logic model_ovr     = 1'b0;
   logic model_valid   = 1'b0;
   logic model_ovr_now = 1'b0;
   int   n_cmp         = 0;
   int   n_err         = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push_matrix(input mat_t mm);
      for (int k = 0; k < 16; k++) begin
         int r;
         int cc;
`ifdef MATMUL_STREAM_COLMAJOR_EN
         r  = k % 4;
         cc = k / 4;
`else
         r  = k / 4;
         cc = k % 4;
`endif
         exp_q.push_back('{data: mm[r][cc], last: (k == 15)});
      end
   endfunction

   function automatic mat_t seq_mat(input int base);
      mat_t mm;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mm[i][j] = DW'(base + i * 4 + j);
      return mm;
   endfunction

   function automatic mat_t rand_mat();
      mat_t mm;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            mm[i][j] = DW'($urandom);
      return mm;
   endfunction

   // One clock of stimulus; the model tracks elements left in the held matrix.
   task automatic step(input logic d, input mat_t cm, input logic rdy);
      logic xfer;
      logic acc;
      @(posedge clk);
      #1;
      done          = d;
      c             = cm;
      u_if.m_ready  = rdy;
      model_valid   = (rem > 0);
      model_ovr_now = model_ovr;
      xfer          = (rem > 0) && rdy;
      acc           = d && ((rem == 0) || (rem == 1 && xfer));
      if (xfer) rem--;
      if (acc) begin
         push_matrix(cm);
         rem = 16;
      end else if (d) begin
         model_ovr = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst           = 1'b1;
      done          = 1'b0;
      u_if.m_ready  = 1'b0;
      exp_q.delete();
      rem           = 0;
      model_ovr     = 1'b0;
      model_valid   = 1'b0;
      model_ovr_now = 1'b0;
      #2;
      check("rst_valid", {31'd0, u_if.m_valid}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_overrun", {31'd0, overrun}, 0);
      check("rst_last", {31'd0, u_if.m_last}, 0);
      check("rst_data", {16'd0, u_if.m_data}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      check("valid", {31'd0, u_if.m_valid}, {31'd0, model_valid});
      check("busy", {31'd0, busy}, {31'd0, model_valid});
      check("overrun", {31'd0, overrun}, {31'd0, model_ovr_now});
      if (model_valid) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL underflow: got element %0h expected none at %0t", u_if.m_data, $time);
         end else begin
            check("data", {16'd0, u_if.m_data}, {16'd0, exp_q[0].data});
            check("last", {31'd0, u_if.m_last}, {31'd0, exp_q[0].last});
            if (u_if.m_ready) void'(exp_q.pop_front());
         end
      end else begin
         check("last_idle", {31'd0, u_if.m_last}, 0);
      end
   end

   initial begin
      mat_t a;
      mat_t b;
      a = seq_mat(0);
      b = seq_mat(16'h100);
      u_if.m_ready = 1'b0;
      do_reset();

      // basic drain
      step(1'b1, a, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, a, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, a, 1'b1);

      // backpressure
      step(1'b1, a, 1'b0);
      for (int i = 0; i < 36; i++) step(1'b0, a, (i % 2) == 0);
      check("bp_drained", exp_q.size(), 0);

      // back-to-back: new done on the transfer of element 15
      step(1'b1, a, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b0, a, 1'b1);
      step(1'b1, b, 1'b1);
      for (int i = 0; i < 18; i++) step(1'b0, b, 1'b1);

      // overrun at index 5
      step(1'b1, a, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b0, a, 1'b1);
      step(1'b1, b, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b0, b, 1'b1);

      // reset mid-stream at index 7
      step(1'b1, a, 1'b1);
      for (int i = 0; i < 7; i++) step(1'b0, a, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, a, 1'b1);
      step(1'b1, b, 1'b1);
      for (int i = 0; i < 18; i++) step(1'b0, b, 1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 9) == 0, rand_mat(), $urandom_range(0, 3) != 0);
      end
      for (int i = 0; i < 40; i++) step(1'b0, a, 1'b1);
      check("final_drained", exp_q.size(), 0);

      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
